// File: rtl/seg7_hex_if.sv
// Display-bus and digit-stream bundle for the 7-segment read-back decoder.
// The slave modport is the decoder's view. The master modport is the view of
// whatever drives the segment bus and consumes the decoded digits.
interface seg7_hex_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 sample_en;
  logic [6:0]           seg_in;
  logic                 dp_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           hex_out;
  logic                 dp_out;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  sample_en, seg_in, dp_in, out_ready,
    output out_valid, hex_out, dp_out, err, err_count
  );

  modport master (
    output sample_en, seg_in, dp_in, out_ready,
    input  out_valid, hex_out, dp_out, err, err_count
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Recovers the hex digit shown on a 7-segment + dp bus.
// A pattern must be seen unchanged for STABLE_CYCLES samples before it counts.
// Each settled, non-blank pattern that differs from the last one handled is
// emitted once on a valid/ready handshake. Glyphs that are not hex digits are
// flagged with err and counted in a saturating counter.
module seg7_hex_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  seg7_hex_if.slave  bus
);
  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SETTLED = 2'd2;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [7:0]           pat_q, pat_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           last_q, last_d;
  logic [1:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic [3:0]           hex_q, hex_d;
  logic                 dp_q, dp_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       stable;
  logic       legal;
  logic [3:0] digit;
  logic [7:0] bus_pat;

  assign bus_pat = {bus.dp_in, bus.seg_in};
  assign stable  = (cnt_q == STABLE_N);

  // Glyph lookup on the sampled segments; dp plays no part in it
  always_comb begin
    legal = 1'b1;
    digit = 4'h0;
    case (pat_q[6:0])
      7'h3F: digit = 4'h0;
      7'h06: digit = 4'h1;
      7'h5B: digit = 4'h2;
      7'h4F: digit = 4'h3;
      7'h66: digit = 4'h4;
      7'h6D: digit = 4'h5;
      7'h7D: digit = 4'h6;
      7'h07: digit = 4'h7;
      7'h7F: digit = 4'h8;
      7'h6F: digit = 4'h9;
      7'h77: digit = 4'hA;
      7'h7C: digit = 4'hB;
      7'h39: digit = 4'hC;
      7'h5E: digit = 4'hD;
      7'h79: digit = 4'hE;
      7'h71: digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // Stability tracker: count consecutive identical samples, frozen when sampling is off
  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    if (bus.sample_en) begin
      pat_d = bus_pat;
      if (bus_pat != pat_q)
        cnt_d = 8'd0;
      else if (!stable)
        cnt_d = cnt_q + 8'd1;
    end
  end

  // Emission FSM: acquire a settled pattern, present it, then wait for a change
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    valid_d   = valid_q;
    hex_d     = hex_q;
    dp_d      = dp_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (stable) begin
          last_d = pat_q;
          // Blank, or a return to the pattern already handled, is absorbed silently
          if (pat_q == 8'h00 || pat_q == last_q) begin
            state_d = ST_SETTLED;
          end else begin
            valid_d = 1'b1;
            hex_d   = legal ? digit : 4'h0;
            dp_d    = pat_q[7];
            err_d   = ~legal;
            if (!legal && err_cnt_q != '1)
              err_cnt_d = err_cnt_q + 1'b1;
            state_d = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_SETTLED;
        end
      end
      ST_SETTLED: begin
        if (pat_q != last_q)
          state_d = ST_ACQUIRE;
      end
      default: state_d = ST_ACQUIRE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= 8'h00;
      cnt_q     <= 8'd0;
      last_q    <= 8'h00;
      state_q   <= ST_ACQUIRE;
      valid_q   <= 1'b0;
      hex_q     <= 4'h0;
      dp_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.hex_out   = hex_q;
  assign bus.dp_out    = dp_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_seg7_hex_decoder.sv
// Bench for seg7_hex_decoder: a cycle reference model built from the glyph
// table and the settle/emit rules, plus directed scenarios and random traffic.
// A second instance with a 2-bit error counter shares the stimulus.
module tb_seg7_hex_decoder;
  localparam int S = 4;

  logic       gclk = 1'b0;
  logic       rst, en, dp, rdy;
  logic [6:0] seg;

  always #5 gclk = ~gclk;

  seg7_hex_if #(.ERR_CNT_W(8)) ifa ();
  seg7_hex_if #(.ERR_CNT_W(2)) ifb ();

  assign ifa.sample_en = en;
  assign ifa.seg_in    = seg;
  assign ifa.dp_in     = dp;
  assign ifa.out_ready = rdy;
  assign ifb.sample_en = en;
  assign ifb.seg_in    = seg;
  assign ifb.dp_in     = dp;
  assign ifb.out_ready = rdy;

  seg7_hex_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(8)) u_dut  (.clk(gclk), .rst(rst), .bus(ifa));
  seg7_hex_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(2)) u_dut2 (.clk(gclk), .rst(rst), .bus(ifb));

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model state
  int m_pat, m_run, m_last, m_hex, m_dp, m_err, m_errs;
  bit m_hunt, m_valid;

  int log_q[$];
  bit prev_valid;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lookup(input int segv);
    for (int i = 0; i < 16; i++)
      if (int'(glyph[i]) == segv) return i;
    return -1;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge worth of the behavioural rules
  task automatic model_step();
    int  in_pat;
    int  d;
    bit  stable;
    in_pat = {24'd0, dp, seg};
    stable = (m_run == S);
    if (rst) begin
      m_pat = 0; m_run = 0; m_last = 0; m_hex = 0; m_dp = 0; m_err = 0; m_errs = 0;
      m_hunt = 1; m_valid = 0;
    end else begin
      if (m_valid) begin
        if (rdy) m_valid = 0;
      end else if (m_hunt) begin
        if (stable) begin
          m_hunt = 0;
          if (m_pat != 0 && m_pat != m_last) begin
            d       = lookup(m_pat % 128);
            m_valid = 1;
            m_hex   = (d < 0) ? 0 : d;
            m_dp    = m_pat / 128;
            m_err   = (d < 0) ? 1 : 0;
            if (d < 0) m_errs++;
          end
          m_last = m_pat;
        end
      end else if (m_pat != m_last) begin
        m_hunt = 1;
      end
      if (en) begin
        m_run = (in_pat == m_pat) ? min_i(m_run + 1, S) : 0;
        m_pat = in_pat;
      end
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    model_step();
    #1;
    chk("out_valid", ifa.out_valid, m_valid);
    chk("hex_out", ifa.hex_out, m_hex);
    chk("dp_out", ifa.dp_out, m_dp);
    chk("err", ifa.err, m_err);
    chk("err_count", ifa.err_count, min_i(m_errs, 255));
    chk("err_count_w2", ifb.err_count, min_i(m_errs, 3));
    chk("out_valid_w2", ifb.out_valid, m_valid);
    if (ifa.out_valid && !prev_valid) log_q.push_back(int'(ifa.hex_out) + 16 * int'(ifa.err));
    prev_valid = ifa.out_valid;
  endtask

  task automatic hold(input logic [6:0] s, input logic d, input int n);
    seg = s;
    dp  = d;
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!ifa.out_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, base;
    rst = 1; en = 1; seg = 7'h00; dp = 0; rdy = 0; prev_valid = 0;
    m_hunt = 1; m_valid = 0;
    repeat (3) tick();
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_count", ifa.err_count, 0);
    rst = 0;
    repeat (6) tick();
    chk("blank_no_emit", log_q.size(), 0);

    // first digit latency and single emission
    seg = 7'h5B;
    wait_valid(20, n);
    chk("latency", n, S + 2);
    chk("digit2", ifa.hex_out, 2);
    chk("digit2_err", ifa.err, 0);
    rdy = 1; tick();
    chk("accept_drop", ifa.out_valid, 0);
    rdy = 0;
    repeat (10) tick();
    chk("no_reemit", log_q.size(), 1);

    // all sixteen glyphs in order
    rdy = 1;
    base = log_q.size();
    for (int d = 0; d < 16; d++) hold(glyph[d], 1'b0, 6);
    tick();
    chk("sweep_n", log_q.size() - base, 16);
    for (int d = 0; d < 16; d++)
      if (base + d < log_q.size()) chk("sweep_digit", log_q[base + d], d);
    chk("sweep_errs", ifa.err_count, 0);

    // short glitch must not produce an extra digit
    base = log_q.size();
    hold(7'h3F, 1'b0, 8);
    hold(7'h06, 1'b0, 2);
    hold(7'h3F, 1'b0, 10);
    chk("glitch_n", log_q.size() - base, 1);
    if (log_q.size() > base) chk("glitch_digit", log_q[base], 0);

    // illegal glyph and saturating counters
    base = log_q.size();
    hold(7'h27, 1'b0, 8);
    chk("illegal_err", ifa.err, 1);
    chk("illegal_hex", ifa.hex_out, 0);
    chk("illegal_cnt1", ifa.err_count, 1);
    repeat (3) begin
      hold(7'h00, 1'b0, 8);
      hold(7'h27, 1'b0, 8);
    end
    chk("illegal_cnt4", ifa.err_count, 4);
    chk("illegal_sat2", ifb.err_count, 3);
    chk("illegal_n", log_q.size() - base, 4);

    // decimal point on a blank digit is illegal
    hold(7'h00, 1'b1, 8);
    chk("dp_blank_err", ifa.err, 1);
    chk("dp_blank_dp", ifa.dp_out, 1);
    chk("dp_blank_cnt", ifa.err_count, 5);

    // back-pressure: presented digit stays put while the bus moves on
    rdy = 0;
    hold(7'h00, 1'b0, 8);
    hold(7'h7F, 1'b0, 8);
    chk("stall_valid", ifa.out_valid, 1);
    chk("stall_hex8", ifa.hex_out, 8);
    hold(7'h71, 1'b0, 10);
    chk("stall_hold_valid", ifa.out_valid, 1);
    chk("stall_hold_hex", ifa.hex_out, 8);
    rdy = 1; tick();
    wait_valid(10, n);
    chk("stall_next_lat", n, 2);
    chk("stall_next_hex", ifa.hex_out, 15);
    base = log_q.size();
    hold(7'h6F, 1'b0, 8);
    hold(7'h00, 1'b0, 8);
    hold(7'h6F, 1'b0, 8);
    chk("nine_twice_n", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      chk("nine_a", log_q[base], 9);
      chk("nine_b", log_q[base + 1], 9);
    end

    // sampling disabled: bus activity is invisible
    base = log_q.size();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      seg = 7'($urandom);
      dp  = 1'($urandom);
      tick();
    end
    en = 1;
    hold(7'h6F, 1'b0, 8);
    chk("frozen_n", log_q.size() - base, 0);

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      rdy  = ($urandom_range(0, 2) != 0);
      en   = ($urandom_range(0, 7) != 0);
      case (kind)
        0: hold(glyph[$urandom_range(0, 15)], 1'($urandom_range(0, 4) == 0), $urandom_range(1, 8));
        1: hold(7'($urandom), 1'($urandom), $urandom_range(1, 8));
        2: hold(7'h00, 1'b0, $urandom_range(1, 8));
        default: hold(seg, dp, $urandom_range(1, 8));
      endcase
    end

    // reset while a digit is being presented
    en = 1; rdy = 0;
    rst = 1; tick();
    rst = 0;
    hold(7'h66, 1'b0, 8);
    chk("pre_rst_valid", ifa.out_valid, 1);
    chk("pre_rst_hex", ifa.hex_out, 4);
    rst = 1; tick();
    chk("rst_mid_valid", ifa.out_valid, 0);
    chk("rst_mid_hex", ifa.hex_out, 0);
    chk("rst_mid_count", ifa.err_count, 0);
    rst = 0; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
